// File: rtl/watch_time_counter.sv
// Watch time-of-day counter: BCD hh:mm:ss with run/set-hour/set-minute modes.
// Advances once per 1 Hz clk edge; all outputs come straight from registers.
module watch_time_counter #(
  parameter int RST_HR  = 0,
  parameter int RST_MIN = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode_btn,
  input  logic       inc_btn,
  output logic [7:0] hr_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic [1:0] mode,
  output logic       day_pulse
);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    SET_HR  = 2'b01,
    SET_MIN = 2'b10
  } state_t;

  localparam logic [7:0] HR_INIT =
    8'(((RST_HR / 10) << 4) | (RST_HR % 10));
  localparam logic [7:0] MIN_INIT =
    8'(((RST_MIN / 10) << 4) | (RST_MIN % 10));

  localparam logic [7:0] HR_LAST = 8'h23;
  localparam logic [7:0] MS_LAST = 8'h59;

  state_t     state;
  logic       mode_q;
  logic       press;
  logic [7:0] hr;
  logic [7:0] mn;
  logic [7:0] sc;

  // Packed-BCD increment that wraps to 00 after 'last'.
  function automatic logic [7:0] bcd_inc(
    input logic [7:0] v,
    input logic [7:0] last
  );
    logic [7:0] r;
    if (v == last)
      r = 8'h00;
    else if (v[3:0] == 4'd9)
      r = {v[7:4] + 4'd1, 4'd0};
    else
      r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  assign press = mode_btn & ~mode_q;

  // Mode FSM and time registers; a press edge only changes mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      mode_q    <= 1'b0;
      hr        <= HR_INIT;
      mn        <= MIN_INIT;
      sc        <= 8'h00;
      day_pulse <= 1'b0;
    end else begin
      mode_q    <= mode_btn;
      day_pulse <= 1'b0;
      case (state)
        RUN: begin
          if (press) begin
            state <= SET_HR;
          end else begin
            sc <= bcd_inc(sc, MS_LAST);
            if (sc == MS_LAST) begin
              mn <= bcd_inc(mn, MS_LAST);
              if (mn == MS_LAST) begin
                hr <= bcd_inc(hr, HR_LAST);
                if (hr == HR_LAST)
                  day_pulse <= 1'b1;
              end
            end
          end
        end
        SET_HR: begin
          if (press)
            state <= SET_MIN;
          else if (inc_btn)
            hr <= bcd_inc(hr, HR_LAST);
        end
        SET_MIN: begin
          if (press) begin
            state <= RUN;
            sc    <= 8'h00;
          end else if (inc_btn) begin
            mn <= bcd_inc(mn, MS_LAST);
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  assign hr_bcd  = hr;
  assign min_bcd = mn;
  assign sec_bcd = sc;
  assign mode    = state;

endmodule

// File: tb/tb_watch_time_counter.sv
// Bench for watch_time_counter: table of stimulus runs with expected
// end state, expectations queued at drive time and checked after each edge.
module tb_watch_time_counter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mode_btn = 1'b0;
  logic inc_btn = 1'b0;

  logic [7:0] hr0, min0, sec0;
  logic [1:0] mode0;
  logic       dp0;
  logic [7:0] hr1, min1, sec1;
  logic [1:0] mode1;
  logic       dp1;

  always #5 clk = ~clk;

  watch_time_counter dut0 (
    .clk(clk), .rst(rst), .mode_btn(mode_btn), .inc_btn(inc_btn),
    .hr_bcd(hr0), .min_bcd(min0), .sec_bcd(sec0),
    .mode(mode0), .day_pulse(dp0)
  );

  watch_time_counter #(.RST_HR(23), .RST_MIN(59)) dut1 (
    .clk(clk), .rst(rst), .mode_btn(mode_btn), .inc_btn(inc_btn),
    .hr_bcd(hr1), .min_bcd(min1), .sec_bcd(sec1),
    .mode(mode1), .day_pulse(dp1)
  );

  typedef struct {
    string      name;
    int         cnt;
    bit         r;
    bit         mb;
    bit         ib;
    bit         sel;
    logic [7:0] h;
    logic [7:0] m;
    logic [7:0] s;
    logic [1:0] md;
    bit         dp;
  } vec_t;

  typedef struct {
    string      name;
    bit         sel;
    bit         full;
    logic [7:0] h;
    logic [7:0] m;
    logic [7:0] s;
    logic [1:0] md;
    bit         dp;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic void add(
    string n, int c, bit r, bit mb, bit ib, bit sel,
    logic [7:0] h, logic [7:0] m, logic [7:0] s,
    logic [1:0] md, bit dp
  );
    vec_t v;
    v.name = n; v.cnt = c; v.r = r; v.mb = mb; v.ib = ib;
    v.sel = sel; v.h = h; v.m = m; v.s = s; v.md = md; v.dp = dp;
    tbl.push_back(v);
  endfunction

  task automatic chk(string nm, int act, int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic check_one();
    exp_t e;
    logic [7:0] h, m, s;
    logic [1:0] md;
    logic dp;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 1, 0);
      return;
    end
    e = sb.pop_front();
    if (e.sel) begin
      h = hr1; m = min1; s = sec1; md = mode1; dp = dp1;
    end else begin
      h = hr0; m = min0; s = sec0; md = mode0; dp = dp0;
    end
    chk({e.name, ".day_pulse"}, int'(dp), int'(e.dp));
    if (e.full) begin
      chk({e.name, ".hr"}, int'(h), int'(e.h));
      chk({e.name, ".min"}, int'(m), int'(e.m));
      chk({e.name, ".sec"}, int'(s), int'(e.s));
      chk({e.name, ".mode"}, int'(md), int'(e.md));
    end
  endtask

  initial begin
    // Rollover with the 23:59 reset instance
    add("rst1",    1,  1, 0, 0, 1, 8'h23, 8'h59, 8'h00, 2'd0, 0);
    add("run59",   59, 0, 0, 0, 1, 8'h23, 8'h59, 8'h59, 2'd0, 0);
    add("roll",    1,  0, 0, 0, 1, 8'h00, 8'h00, 8'h00, 2'd0, 1);
    add("post",    1,  0, 0, 0, 1, 8'h00, 8'h00, 8'h01, 2'd0, 0);
    // Default instance
    add("rst0",    1,  1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 2'd0, 0);
    add("idle61",  61, 0, 0, 0, 0, 8'h00, 8'h01, 8'h01, 2'd0, 0);
    add("p_hr",    1,  0, 1, 0, 0, 8'h00, 8'h01, 8'h01, 2'd1, 0);
    add("inc10",   10, 0, 0, 1, 0, 8'h10, 8'h01, 8'h01, 2'd1, 0);
    add("p_min",   1,  0, 1, 0, 0, 8'h10, 8'h01, 8'h01, 2'd2, 0);
    add("inc19",   19, 0, 0, 1, 0, 8'h10, 8'h20, 8'h01, 2'd2, 0);
    add("p_run",   1,  0, 1, 0, 0, 8'h10, 8'h20, 8'h00, 2'd0, 0);
    add("run30",   30, 0, 0, 0, 0, 8'h10, 8'h20, 8'h30, 2'd0, 0);
    add("hr_p",    1,  0, 1, 0, 0, 8'h10, 8'h20, 8'h30, 2'd1, 0);
    add("hr_inc",  15, 0, 0, 1, 0, 8'h01, 8'h20, 8'h30, 2'd1, 0);
    add("min_p",   1,  0, 1, 0, 0, 8'h01, 8'h20, 8'h30, 2'd2, 0);
    add("min_inc", 45, 0, 0, 1, 0, 8'h01, 8'h05, 8'h30, 2'd2, 0);
    add("run_p",   1,  0, 1, 0, 0, 8'h01, 8'h05, 8'h00, 2'd0, 0);
    add("run_nxt", 1,  0, 0, 0, 0, 8'h01, 8'h05, 8'h01, 2'd0, 0);
    add("hold10",  10, 0, 1, 0, 0, 8'h01, 8'h05, 8'h01, 2'd1, 0);
    add("rel",     1,  0, 0, 0, 0, 8'h01, 8'h05, 8'h01, 2'd1, 0);
    add("p_inc",   1,  0, 1, 1, 0, 8'h01, 8'h05, 8'h01, 2'd2, 0);
    add("m34",     29, 0, 0, 1, 0, 8'h01, 8'h34, 8'h01, 2'd2, 0);
    add("to_run",  1,  0, 1, 0, 0, 8'h01, 8'h34, 8'h00, 2'd0, 0);
    add("rel2",    1,  0, 0, 0, 0, 8'h01, 8'h34, 8'h01, 2'd0, 0);
    add("p_hr2",   1,  0, 1, 0, 0, 8'h01, 8'h34, 8'h01, 2'd1, 0);
    add("h12",     11, 0, 0, 1, 0, 8'h12, 8'h34, 8'h01, 2'd1, 0);
    add("p_min2",  1,  0, 1, 0, 0, 8'h12, 8'h34, 8'h01, 2'd2, 0);
    add("rst_mid", 1,  1, 0, 1, 0, 8'h00, 8'h00, 8'h00, 2'd0, 0);
    add("first",   1,  0, 0, 0, 0, 8'h00, 8'h00, 8'h01, 2'd0, 0);
    add("inc_ign", 3,  0, 0, 1, 0, 8'h00, 8'h00, 8'h04, 2'd0, 0);

    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].cnt; k++) begin
        exp_t e;
        @(negedge clk);
        rst      = tbl[i].r;
        mode_btn = tbl[i].mb;
        inc_btn  = tbl[i].ib;
        e.name = $sformatf("%s[%0d]", tbl[i].name, k);
        e.sel  = tbl[i].sel;
        e.full = (k == tbl[i].cnt - 1);
        e.h = tbl[i].h; e.m = tbl[i].m; e.s = tbl[i].s;
        e.md = tbl[i].md;
        e.dp = e.full ? tbl[i].dp : 1'b0;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_one();
      end
    end

    chk("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
